// File: rtl/id_pkg.sv
// Shared decode definitions for the MIPS-subset ID stage.
// Latency: n/a (constants, types and pure combinational functions only).
// Backpressure: n/a.
//
// Holds opcode/funct constants, ALU op encodings, the packed control word
// and the decode function used by id_stage_pipelined.
package id_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation encodings presented to EX
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       regdst;    // 1: destination is rd, 0: destination is rt
        logic [2:0] aluc;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Main decoder. Unrecognised opcode or funct yields only the illegal flag.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
                case (funct)
                    FN_ADD:  c.aluc = ALU_ADD;
                    FN_SUB:  c.aluc = ALU_SUB;
                    FN_AND:  c.aluc = ALU_AND;
                    FN_OR:   c.aluc = ALU_OR;
                    FN_SLT:  c.aluc = ALU_SLT;
                    default: begin
                        c         = CTRL_NOP;
                        c.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                c.aluc     = ALU_ADD;
                c.alusrc   = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            OP_SW: begin
                c.aluc     = ALU_ADD;
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            OP_BEQ: begin
                c.aluc   = ALU_SUB;
                c.branch = 1'b1;
            end
            OP_ADDI: begin
                c.aluc     = ALU_ADD;
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Instructions that actually read rt as a source operand. addi/lw use the
    // rt field as a destination, so a match there is not a load-use hazard.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file, two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles (write-first bypass), writes visible next cycle.
// Backpressure: none; always accepts a write.
//
// Ports: clk/rst_n; ra1/ra2 read addresses -> rd1/rd2 data;
//        we/wa/wd write enable, address, data. Register 0 is hardwired to 0.
module regfile_bypass #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RA    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA-1:0]   ra1,
    input  logic [RA-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RA-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_live;

    // Writes to r0 are dropped so it never needs special handling downstream.
    assign wr_live = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wa] <= wd;
        end
    end

    // Same-cycle write wins over the stored value so ID sees the result
    // that write-back is committing right now.
    always_comb begin
        rd1 = mem[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wr_live && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = mem[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wr_live && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// Pipelined MIPS-subset instruction decode with registered ID/EX outputs.
// Latency: instruction accepted in cycle n appears on ex_* in cycle n+1.
// Backpressure: holds ID/EX while !ex_ready; stalls fetch one cycle on load-use.
//
// Ports: if_valid/if_instr/id_ready fetch handshake; flush squashes the ID
// instruction; wb_we/wb_rd/wb_data register write-back; ex_ready/ex_valid and
// ex_* carry the decoded instruction (operands, immediate, fields, controls).
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RA    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RA-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA-1:0]   ex_rs,
    output logic [RA-1:0]   ex_rt,
    output logic [RA-1:0]   ex_rd,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic [2:0]      ex_aluc,
    output logic            ex_illegal
);

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rs_f;
    logic [4:0]      rt_f;
    logic [4:0]      rd_f;
    logic [RA-1:0]   rs;
    logic [RA-1:0]   rt;
    logic [RA-1:0]   rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    ctrl_t           dec;
    logic            use_rt;
    logic            hazard;
    logic            adv;
    logic            load;
    logic            unused_fields;

    assign op    = if_instr[31:26];
    assign funct = if_instr[5:0];
    assign rs_f  = if_instr[25:21];
    assign rt_f  = if_instr[20:16];
    assign rd_f  = if_instr[15:11];

    // Register fields narrower than 5 bits when NREGS < 32: keep the low bits.
    assign rs = rs_f[RA-1:0];
    assign rt = rt_f[RA-1:0];
    assign rd = rd_f[RA-1:0];

    // High field bits are intentionally dropped for small register files.
    assign unused_fields = ^{rs_f, rt_f, rd_f};

    assign imm = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    assign dec    = decode(op, funct);
    assign use_rt = uses_rt(op);

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rdata1),
        .rd2   (rdata2),
        .we    (wb_we),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    // A load in EX whose target feeds this instruction cannot be forwarded in
    // time; hold the instruction in fetch and send a bubble instead. Loads to
    // r0 never produce a usable value, so they are excluded.
    assign hazard = ex_valid && ex_memread && (ex_rt != '0) &&
                    ((ex_rt == rs) || ((ex_rt == rt) && use_rt));

    assign adv      = !ex_valid || ex_ready;
    // flush always consumes: the squashed instruction is dropped even when
    // ID/EX is stalled and cannot load the bubble yet.
    assign id_ready = flush || (adv && !hazard);
    assign load     = adv && !flush && !hazard && if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluc     <= 3'b000;
            ex_illegal  <= 1'b0;
        end else if (adv) begin
            // Bubbles carry zero controls so EX can ignore ex_valid if it wants.
            ex_valid    <= load;
            ex_branch   <= load && dec.branch;
            ex_memread  <= load && dec.memread;
            ex_memtoreg <= load && dec.memtoreg;
            ex_memwrite <= load && dec.memwrite;
            ex_alusrc   <= load && dec.alusrc;
            ex_regwrite <= load && dec.regwrite;
            ex_aluc     <= load ? dec.aluc : 3'b000;
            ex_illegal  <= load && dec.illegal;
            // Data fields only move with a live instruction to avoid toggling.
            if (load) begin
                ex_rdata1 <= rdata1;
                ex_rdata2 <= rdata2;
                ex_imm    <= imm;
                ex_rs     <= rs;
                ex_rt     <= rt;
                ex_rd     <= dec.regdst ? rd : rt;
            end
        end
    end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised, pipelined MIPS-subset instruction-decode stage. Accepts an instruction from fetch over a valid/ready handshake, decodes control, reads the register file (with write-back bypass), sign-extends the immediate, and registers everything into an ID/EX pipeline register with a one-cycle latency. Adds what the single-cycle decoder lacks: backpressure, load-use hazard stall with bubble insertion, branch flush, and width/depth parameters.

## Interface
- XLEN, 32, datapath width; immediate sign-extended to XLEN
- NREGS, 32, architectural register count (power of two); RA = log2(NREGS) address bits, instruction fields truncated to RA
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  if_instr holds an instruction
- if_instr  in  32  instruction word
- id_ready  out  1  ID consumes if_instr this cycle
- flush  in  1  squash the instruction in ID; load a bubble
- wb_we  in  1  write-back enable
- wb_rd  in  RA  write-back destination
- wb_data  in  XLEN  write-back data
- ex_ready  in  1  EX accepts the ID/EX contents this cycle
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_rdata1, ex_rdata2  out  XLEN  register operands (rs, rt)
- ex_imm  out  XLEN  sign-extended instr[15:0]
- ex_rs, ex_rt, ex_rd  out  RA  source fields; ex_rd is the final destination (rt or rd per RegDst)
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1  control
- ex_aluc  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- ex_illegal  out  1  unrecognised opcode/funct; all other controls 0

## Operation
- Decode: R-type (op 0x00) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt → regwrite, RegDst=rd. lw 0x23: add, alusrc, memread, memtoreg, regwrite, dest=rt. sw 0x2B: add, alusrc, memwrite. beq 0x04: sub, branch. addi 0x08: add, alusrc, regwrite, dest=rt. Anything else: ex_illegal=1, all controls 0, aluc 000.
- Register file: NREGS×XLEN, two combinational reads, one synchronous write; register 0 reads 0, writes to it ignored; all registers clear on reset. Read of an address being written the same cycle (wb_we, wb_rd≠0) returns wb_data.
- Advance condition adv = !ex_valid || ex_ready.
- Hazard h = ex_valid && ex_memread && ex_rt≠0 && (ex_rt==rs || (ex_rt==rt && instruction uses rt: R-type, sw, beq)).
- id_ready = flush || (adv && !h).
- On adv: flush → ex_valid←0; else h → ex_valid←0 (bubble); else ex_valid←if_valid, fields loaded. When !adv the ID/EX register holds all values.
- Bubble/invalid loads: ex_valid=0 and all control outputs 0; data fields don't-care.
- flush with if_valid: instruction is consumed and dropped. flush while !adv: ID/EX contents unaffected, the ID instruction still dropped.

## Timing
- Latency: if_instr accepted in cycle n appears on ex_* in cycle n+1.
- Load-use: exactly one bubble when EX is advancing; instruction re-presented by fetch (if_valid held, id_ready=0) accepted the following cycle.
- Write-back same-cycle as read: bypassed value registered into ex_rdata*.
- Reset (async, any time including mid-stall): ex_valid=0, all ex_* outputs 0, register file 0; id_ready follows its equation (=1 after reset since ex_valid=0).
- Fetch contract: if_valid/if_instr stable while if_valid && !id_ready.

## Structure
- Shared package id_pkg: opcode and funct constants, aluc encodings, packed ctrl_t struct (branch, memread, memtoreg, memwrite, alusrc, regwrite, regdst, aluc, illegal), CTRL_NOP constant.
- One sub-module: regfile_bypass (parameters XLEN, NREGS; async reset clear, write-first bypass, r0 zero). Decode logic is a function in id_pkg.

## Test plan
- Reset then addi $1,$0,5 (0x20010005), ex_ready=1 → next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_alusrc=1, ex_regwrite=1, ex_aluc=010.
- wb_we=1 wb_rd=3 wb_data=0xDEADBEEF same cycle as add $4,$3,$0 → ex_rdata1=0xDEADBEEF; wb_rd=0 write → $0 still reads 0.
- lw $2,0($1) followed by add $5,$2,$2 → id_ready=0 for one cycle, one bubble (ex_valid=0), add issued next with ex_rs=2; lw into $0 then use → no stall.
- ex_ready=0 for 3 cycles with valid instruction in ID/EX → ex_* stable, id_ready=0; release → normal flow, nothing lost or duplicated.
- flush asserted with beq in ID → id_ready=1, next cycle ex_valid=0, controls 0; opcode 0x3F → ex_illegal=1, ex_regwrite=0.
- rst_n dropped asynchronously mid-stall → ex_valid and controls 0 immediately, before next clk edge.
